// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU lab board keypad input path: key codes,
// debounce state encoding and BCD helpers.
package alu_io_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hC;

   localparam int unsigned MAX_DIGITS = 4;

   localparam logic [1:0] StIdle        = 2'd0;
   localparam logic [1:0] StPressWait   = 2'd1;
   localparam logic [1:0] StHeld        = 2'd2;
   localparam logic [1:0] StReleaseWait = 2'd3;

   // Index 0 is the least significant digit.
   typedef logic [MAX_DIGITS-1:0][3:0] bcd_t;

   function automatic logic [13:0] bcd_to_bin(input bcd_t d);
      return 14'(d[3]) * 14'd1000 + 14'(d[2]) * 14'd100 + 14'(d[1]) * 14'd10 + 14'(d[0]);
   endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Keypad-to-display bundle of the operand entry controller.
interface operand_entry_if;

   logic        key_valid;
   logic [3:0]  key_code;
   logic [13:0] operand;
   logic [2:0]  number_of_digits;
   logic [3:0]  digit0;
   logic [3:0]  digit1;
   logic [3:0]  digit2;
   logic [3:0]  digit3;
   logic        operand_valid;
   logic        overflow;

   modport master (
      output key_valid, key_code,
      input  operand, number_of_digits, digit0, digit1, digit2, digit3, operand_valid, overflow
   );

   modport slave (
      input  key_valid, key_code,
      output operand, number_of_digits, digit0, digit1, digit2, digit3, operand_valid, overflow
   );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes a raw key strobe and code, and emits one accept pulse per
// debounced press.
module key_debouncer
   import alu_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid_i,
   input  logic [3:0] key_code_i,
   output logic       accept_o,
   output logic [3:0] code_o
);

   localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES);

   logic [1:0]  valid_sync_q;
   logic [3:0]  code_s1_q, code_s2_q;
   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        level;

   assign level  = valid_sync_q[1];
   assign code_o = code_s2_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (level) begin
               state_d = StPressWait;
               cnt_d   = 16'd1;
            end
         end
         StPressWait: begin
            if (!level) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               accept_o = 1'b1;
               state_d  = StHeld;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StHeld: begin
            if (!level) begin
               state_d = StReleaseWait;
               cnt_d   = 16'd1;
            end
         end
         StReleaseWait: begin
            // A bounce back to 1 keeps the key held, so no second accept.
            if (level) begin
               state_d = StHeld;
            end else if (cnt_q == CntMax) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_sync_q <= '0;
         code_s1_q    <= '0;
         code_s2_q    <= '0;
         state_q      <= StIdle;
         cnt_q        <= '0;
      end else begin
         valid_sync_q <= {valid_sync_q[0], key_valid_i};
         code_s1_q    <= key_code_i;
         code_s2_q    <= code_s1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: debounced key actions edit a four-digit decimal entry
// presented as BCD digits, a binary operand and a digit count.
module operand_entry
   import alu_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   operand_entry_if.slave  entry_io
);

   logic        accept;
   logic [3:0]  code;
   bcd_t        digit_q, digit_d;
   logic [2:0]  count_q, count_d;
   logic        fresh_q, fresh_d;
   logic [13:0] operand_q;
   logic        valid_q, valid_d;
   logic        ovf_q, ovf_d;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid_i(entry_io.key_valid),
      .key_code_i (entry_io.key_code),
      .accept_o   (accept),
      .code_o     (code)
   );

   always_comb begin
      digit_d = digit_q;
      count_d = count_q;
      fresh_d = fresh_q;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      if (accept) begin
         if (code <= 4'd9) begin
            // fresh_q: the last action was enter, so a digit starts a new entry.
            if (fresh_q) begin
               digit_d    = '0;
               digit_d[0] = code;
               count_d    = (code == 4'd0) ? 3'd0 : 3'd1;
               fresh_d    = 1'b0;
            end else if (count_q == 3'(MAX_DIGITS)) begin
               ovf_d = 1'b1;
            end else if (!(count_q == 3'd0 && code == 4'd0)) begin
               digit_d = {digit_q[MAX_DIGITS-2:0], code};
               count_d = count_q + 3'd1;
            end
         end else begin
            case (code)
               KEY_CLEAR: begin
                  digit_d = '0;
                  count_d = 3'd0;
                  fresh_d = 1'b0;
               end
               KEY_BACK: begin
                  if (count_q != 3'd0) begin
                     digit_d = {4'd0, digit_q[MAX_DIGITS-1:1]};
                     count_d = count_q - 3'd1;
                  end
                  fresh_d = 1'b0;
               end
               KEY_ENTER: begin
                  valid_d = 1'b1;
                  fresh_d = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q   <= '0;
         count_q   <= '0;
         fresh_q   <= 1'b0;
         operand_q <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         digit_q   <= digit_d;
         count_q   <= count_d;
         fresh_q   <= fresh_d;
         operand_q <= bcd_to_bin(digit_d);
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
      end
   end

   assign entry_io.operand          = operand_q;
   assign entry_io.number_of_digits = count_q;
   assign entry_io.digit0           = digit_q[0];
   assign entry_io.digit1           = digit_q[1];
   assign entry_io.digit2           = digit_q[2];
   assign entry_io.digit3           = digit_q[3];
   assign entry_io.operand_valid    = valid_q;
   assign entry_io.overflow         = ovf_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry against a decimal-value model of the entry.
module tb_operand_entry;

   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   operand_entry_if bus_if ();

   operand_entry #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .entry_io(bus_if)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Model: the entry is an integer value with a digit count.
   int m_val = 0;
   int m_cnt = 0;
   bit m_fresh = 1'b0;
   bit m_valid = 1'b0;
   bit m_ovf = 1'b0;

   function automatic logic [32:0] obs();
      return {bus_if.operand, bus_if.number_of_digits, bus_if.digit3, bus_if.digit2,
              bus_if.digit1, bus_if.digit0};
   endfunction

   function automatic logic [32:0] exp_vec();
      return {14'(m_val), 3'(m_cnt), 4'((m_val / 1000) % 10), 4'((m_val / 100) % 10),
              4'((m_val / 10) % 10), 4'(m_val % 10)};
   endfunction

   function automatic void model_reset();
      m_val = 0; m_cnt = 0; m_fresh = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
   endfunction

   function automatic void model_key(input logic [3:0] c);
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      if (c <= 4'd9) begin
         if (m_fresh) begin
            m_val = int'(c); m_cnt = (c != 4'd0) ? 1 : 0; m_fresh = 1'b0;
         end else if (m_cnt == 4) begin
            m_ovf = 1'b1;
         end else if (!(m_cnt == 0 && c == 4'd0)) begin
            m_val = m_val * 10 + int'(c); m_cnt++;
         end
      end else if (c == 4'hA) begin
         m_val = 0; m_cnt = 0; m_fresh = 1'b0;
      end else if (c == 4'hB) begin
         if (m_cnt > 0) begin
            m_val = m_val / 10; m_cnt--;
         end
         m_fresh = 1'b0;
      end else if (c == 4'hC) begin
         m_valid = 1'b1; m_fresh = 1'b1;
      end
   endfunction

   // Holds the key from a negedge; returns at edge E+D+2 (+1), pre sampled at E+D+1 (+1).
   task automatic press_key(input logic [3:0] c, output logic [32:0] pre);
      @(negedge clk);
      bus_if.key_code  = c;
      bus_if.key_valid = 1'b1;
      @(posedge clk);
      repeat (D + 1) @(posedge clk);
      #1 pre = obs();
      @(posedge clk);
      #1;
   endtask

   task automatic release_key();
      @(negedge clk);
      bus_if.key_valid = 1'b0;
      repeat (2 * D + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus_if.key_valid = 1'b0;
      bus_if.key_code  = 4'h0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_outputs got %h want %h", obs(), exp_vec());
      end
      n_cmp++;
      if ({bus_if.operand_valid, bus_if.overflow} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_pulses got %b want 00", {bus_if.operand_valid, bus_if.overflow});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_digits();
      logic [32:0] pre, e_old;
      for (int i = 1; i <= 4; i++) begin
         e_old = exp_vec();
         press_key(4'(i), pre);
         model_key(4'(i));
         n_cmp++;
         if (pre !== e_old) begin
            n_fail++; $display("FAIL early_update_%0d got %h want %h", i, pre, e_old);
         end
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_fail++; $display("FAIL digit_%0d got %h want %h", i, obs(), exp_vec());
         end
         release_key();
      end
   endtask

   task automatic test_overflow_backspace();
      logic [32:0] pre;
      press_key(4'd5, pre);
      model_key(4'd5);
      n_cmp++;
      if (obs() !== exp_vec() || bus_if.overflow !== m_ovf) begin
         n_fail++;
         $display("FAIL overflow got %h/%b want %h/%b", obs(), bus_if.overflow, exp_vec(), m_ovf);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.overflow !== 1'b0) begin
         n_fail++; $display("FAIL overflow_width got %b want 0", bus_if.overflow);
      end
      release_key();
      press_key(4'hB, pre);
      model_key(4'hB);
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL backspace got %h want %h", obs(), exp_vec());
      end
      release_key();
   endtask

   task automatic test_enter();
      logic [32:0] pre;
      press_key(4'hC, pre);
      model_key(4'hC);
      n_cmp++;
      if (obs() !== exp_vec() || bus_if.operand_valid !== m_valid) begin
         n_fail++;
         $display("FAIL enter got %h/%b want %h/%b", obs(), bus_if.operand_valid, exp_vec(), m_valid);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.operand_valid !== 1'b0 || obs() !== exp_vec()) begin
         n_fail++;
         $display("FAIL enter_width got %h/%b want %h/0", obs(), bus_if.operand_valid, exp_vec());
      end
      release_key();
      press_key(4'd9, pre);
      model_key(4'd9);
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL fresh_entry got %h want %h", obs(), exp_vec());
      end
      release_key();
   endtask

   task automatic test_glitch();
      logic [32:0] e_old;
      logic [6:0]  bounce;
      e_old = exp_vec();
      @(negedge clk);
      bus_if.key_code  = 4'd7;
      bus_if.key_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus_if.key_valid = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs() !== e_old) begin
         n_fail++; $display("FAIL glitch got %h want %h", obs(), e_old);
      end
      bounce = 7'b1011111;
      bus_if.key_code = 4'd1;
      for (int i = 6; i >= 0; i--) begin
         bus_if.key_valid = bounce[i];
         @(negedge clk);
      end
      repeat (D + 6) @(negedge clk);
      release_key();
      model_key(4'd1);
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL bounce got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_zero_clear_ignored();
      logic [3:0]  keys [7];
      logic [32:0] pre;
      keys = '{4'hA, 4'h0, 4'h4, 4'h2, 4'hA, 4'h4, 4'hE};
      for (int i = 0; i < 7; i++) begin
         press_key(keys[i], pre);
         model_key(keys[i]);
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_fail++;
            $display("FAIL edit_key_%0d code %h got %h want %h", i, keys[i], obs(), exp_vec());
         end
         release_key();
      end
   endtask

   task automatic test_reset_mid();
      logic [32:0] pre;
      logic [3:0]  keys [3];
      keys = '{4'hA, 4'h5, 4'h6};
      for (int i = 0; i < 3; i++) begin
         press_key(keys[i], pre);
         model_key(keys[i]);
         release_key();
      end
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL pre_reset got %h want %h", obs(), exp_vec());
      end
      @(negedge clk);
      bus_if.key_code  = 4'd7;
      bus_if.key_valid = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL async_reset got %h want %h", obs(), exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      repeat (D + 1) @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL held_early got %h want %h", obs(), exp_vec());
      end
      @(posedge clk);
      #1;
      model_key(4'd7);
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL held_after_reset got %h want %h", obs(), exp_vec());
      end
      release_key();
   endtask

   task automatic test_random();
      logic [32:0] pre;
      logic [3:0]  c;
      for (int i = 0; i < 40; i++) begin
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         press_key(c, pre);
         model_key(c);
         n_cmp++;
         if (obs() !== exp_vec() || bus_if.operand_valid !== m_valid || bus_if.overflow !== m_ovf)
         begin
            n_fail++;
            $display("FAIL random_%0d code %h got %h/%b%b want %h/%b%b", i, c, obs(),
                     bus_if.operand_valid, bus_if.overflow, exp_vec(), m_valid, m_ovf);
         end
         release_key();
      end
   endtask

   initial begin
      test_reset();
      test_digits();
      test_overflow_backspace();
      test_enter();
      test_glitch();
      test_zero_clear_ignored();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_entry.md
# operand_entry

Keypad operand-entry controller for the ALU lab board: the input-side counterpart of the display controller. Debounces one raw key strobe, decodes a 4-bit key code, and builds a decimal operand of up to four digits, edited with backspace and clear. It outputs the binary operand, the BCD digits, and the digit count for the display path. It also pulses `operandValid` when the user commits the entry to the ALU.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles a level must hold to count as a press or a release; legal range 2..65535.
- `clk` input 1: single clock; all state is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset; one clock, reset asynchronous and active-low.
- `keyValid` input 1: raw, asynchronous, bouncy key-down strobe.
- `keyCode` input 4: key identity, held stable while `keyValid` is high. Codes: 0–9 digit, 4'hA clear, 4'hB backspace, 4'hC enter, 4'hD–4'hF ignored.
- `operand` output 14: binary value of the current entry, 0..9999.
- `numberOfDigits` output 3: digits entered, 0..4.
- `digit0`..`digit3` output 4 each: BCD digits; `digit0` is the least significant; unused positions are 0.
- `operandValid` output 1: one-cycle pulse on enter.
- `overflow` output 1: one-cycle pulse when a digit is rejected because 4 digits are already present.

## Operation
- `keyValid` and `keyCode` each pass through a 2-flop synchronizer.
- Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE→PRESS_WAIT when the synchronized `keyValid` is 1; the counter loads 1.
  - PRESS_WAIT: the counter increments while the level is 1. When the counter reaches `DEBOUNCE_CYCLES`, the FSM issues one accept strobe, captures the synchronized `keyCode`, and goes to HELD. A 0 during PRESS_WAIT returns the FSM to IDLE with no action.
  - HELD→RELEASE_WAIT on level 0; the counter loads 1.
  - RELEASE_WAIT: after `DEBOUNCE_CYCLES` consecutive zeros the FSM goes to IDLE. A 1 during RELEASE_WAIT returns it to HELD.
  - Exactly one action per physical press; holding the key never auto-repeats.
- Actions on accept:
  - Digit d, count < 4: shift the digits left, set `digit0`=d, count+1.
  - Digit d when count==0 and d==0: leading zero; no change.
  - Digit when count==4: no change; `overflow` pulses.
  - Digit when the previous action was enter: start a fresh entry (`digit0`=d, other digits 0, count=1, or count=0 if d==0).
  - Backspace: shift the digits right, `digit3`=0, count−1. At count 0, no change.
  - Clear: all digits 0, count 0.
  - Enter: `operandValid` pulses. The operand and digits hold their values for the display, and the next digit starts a fresh entry.
  - Codes D–F: no change.
- `operand` = d3·1000 + d2·100 + d1·10 + d0, registered from the next-state digits so it changes on the same edge as they do. Intermediate width is 14 bits; the maximum value 9999 fits without truncation.
- Reset mid-operation (including mid-debounce) aborts the operation immediately. A key still held after reset deasserts is treated as a new press.

## Timing
- Reset values: `operand`=0, `numberOfDigits`=0, `digit0..3`=0, `operandValid`=0, `overflow`=0; FSM=IDLE; counters 0; both synchronizers 0.
- Press latency: with `keyValid` stable at 1 from edge E (the first edge that samples it), outputs update at edge E+DEBOUNCE_CYCLES+2. `operandValid` and `overflow` are high for exactly the cycle following that edge.
- Release must be debounced before the next press is accepted. The minimum press-to-press spacing is therefore 2·DEBOUNCE_CYCLES+2 cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no action.
- `keyCode` must be stable from 2 cycles before accept through accept.

## Structure
- Package `alu_io_pkg`:
  - key code localparams (`KEY_CLEAR`, `KEY_BACK`, `KEY_ENTER`);
  - the debounce state encoding;
  - `MAX_DIGITS`=4.
- Sub-module `key_debouncer` (synchronizer, debounce FSM, counter; outputs `accept` and `code`). The digit-edit datapath and the BCD-to-binary conversion stay in `operand_entry`.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4.
- Press 1, 2, 3, 4, each cleanly held → `operand`=1234, `numberOfDigits`=4, `digit3..0`=1,2,3,4. Each update occurs 6 edges after its press is first sampled.
- Press 5 after 1234 → no change; `overflow` high for 1 cycle. Then backspace → `operand`=123, count 3, `digit3`=0.
- `keyValid` glitch of 3 cycles carrying code 7, then 10 cycles low → no output change. Bouncing press 1-0-1-1-1-1-1 → exactly one digit entered.
- Enter on 123 → `operandValid` high for exactly 1 cycle with `operand`=123 stable. Then press 9 → `operand`=9, count 1.
- Press 0 at count 0 → unchanged (0, count 0). Clear after 42 → 0, count 0. Code 4'hE → no change.
- Assert `rst_n`=0 mid-PRESS_WAIT with 56 entered → all outputs 0 asynchronously. The key still held at release of reset yields digit entry only after a full debounce.
